irq_ctrl: RTL
=============

# irq_ctrl

Interrupt entry/exit controller sitting directly upstream of the banked register file. Samples external interrupt lines, waits for an instruction boundary with interrupts enabled in the user control register, saves the user PC into system register sR1 via `sr1_wr`, and switches `bank` to the system bank. On a return-from-interrupt strobe it switches back to the user bank.

## Interface
Parameters:
- `NIRQ`, 4: number of interrupt request lines (1..8).
- `IE_BIT`, 0: bit of `cr_rd` that is the user-mode interrupt-enable flag.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `irq`  in  NIRQ  asynchronous interrupt request lines, active high.
- `cr_rd`  in  16  control register of the current bank, from the register file.
- `pc`  in  16  current user PC (user R7), from the register file.
- `instr_done`  in  1  one-cycle strobe: instruction boundary reached.
- `reti`  in  1  return-from-interrupt decoded; qualified by `instr_done`.
- `bank`  out  1  register bank select: 0 = user, 1 = system.
- `sr1_wr`  out  16  saved-PC write value to sR1; 0 = no write.
- `stall`  out  1  sequencer must hold PC increment and issue.
- `irq_ack`  out  NIRQ  one-hot, one-cycle acknowledge of the serviced line.
- `irq_cause`  out  3  index of the line being / last serviced.

## Operation
- Reset values: `bank`=0, `sr1_wr`=0, `stall`=0, `irq_ack`=0, `irq_cause`=0, pending=0, state=IDLE, synchronizer flops=0.
- Edge detect: each synchronized `irq[i]` rising edge sets sticky `pending[i]`. Cleared only by its own ack; set and clear in the same cycle leaves it set.
- Priority: lowest pending index wins.
- FSM:
  - IDLE (`bank`=0): if any pending && `cr_rd[IE_BIT]` && `instr_done` -> SAVE. Register `sr1_wr`<=`pc`, `irq_cause`<=winner, `stall`<=1. `reti` ignored here.
  - SAVE: `sr1_wr` held at saved PC for this full cycle. -> ENTER.
  - ENTER: `sr1_wr`<=0, `bank`<=1, `irq_ack[cause]`<=1 for one cycle, clear `pending[cause]`, `stall`<=0. -> SYS.
  - SYS (`bank`=1): no nesting; pending bits keep accumulating. On `reti && instr_done` -> IDLE, `bank`<=0.
- Known limitation: the register file ignores `sr1_wr`=0, so an interrupt taken at `pc`=0 does not update sR1. Documented, not corrected.
- `cr_rd[IE_BIT]` is sampled only in IDLE; clearing it later does not abort an entry in progress.
- Reset asserted mid-entry or in SYS: immediate return to reset values; pending interrupts are lost.

## Timing
- All outputs are registered on the rising edge. The register file samples on the falling edge, so each output value is stable for that falling edge.
- Entry latency, counted from the rising edge where IDLE sees pending && IE && `instr_done`:
  - edge 0: `stall`=1, `sr1_wr`=`pc`.
  - edge 1: SAVE ends.
  - edge 2: `bank`=1, `irq_ack` pulse, `stall`=0.
- Total `stall` duration: 2 cycles.
- Input latency with `IRQ_SYNC_EN`: `irq` edge -> pending set after 3 rising edges (2 synchronizer + 1 pending). Without it: 1 edge.
- Exit: `bank` drops to 0 on the edge after `reti && instr_done` in SYS.
- `instr_done` in SAVE or ENTER is ignored; the sequencer must not produce it while `stall`=1.

## Configuration
- `IRQ_SYNC_EN`, defined: two-flop synchronizer per `irq` line ahead of edge detection. Use when `irq` comes from outside the `clk` domain.
- `IRQ_SYNC_EN`, undefined: `irq` is treated as synchronous to `clk` and goes straight to the edge detector (one register stage). This saves 2×NIRQ flops and 2 cycles of latency.

## Test plan
- Basic entry: `IRQ_SYNC_EN` on, `cr_rd`=16'h0001, `pc`=16'h0124. Pulse `irq[2]`, then `instr_done`. Required: `sr1_wr`=16'h0124 for 2 cycles, `stall` high 2 cycles, then `bank`=1, `irq_ack`=4'b0100 for one cycle, `irq_cause`=2.
- Disabled: `cr_rd`=16'h0000, pulse `irq[0]`, repeated `instr_done`. Required: no entry, `bank` stays 0. Then set `cr_rd`=16'h0001: entry occurs on the next `instr_done`.
- Priority and return: `irq[3]` and `irq[1]` rise together. Required: line 1 serviced first, and `bank` stays 1 while `irq[3]` stays pending. Then `reti`+`instr_done`: `bank`=0 next edge, and line 3 entry occurs on the next `instr_done`.
- No nesting: in SYS, pulse `irq[0]`. Required: no second `sr1_wr`/`irq_ack` until after `reti`. `instr_done` without `reti` keeps `bank`=1.
- Reset mid-entry: assert `reset`=0 during SAVE. Required: immediately `bank`=0, `sr1_wr`=0, `stall`=0, pending cleared. After release, no entry without a new `irq` edge.
- Sync off: build without `IRQ_SYNC_EN`. Required: `irq` edge to pending takes exactly 1 cycle, and entry proceeds on the next `instr_done`.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt entry/exit controller ahead of the banked register file.
// Latches interrupt request edges as pending bits. At an instruction boundary
// with interrupts enabled, it saves the user PC to sR1 and switches to the
// system bank. A qualified reti switches back to the user bank.
//
// Build option: define IRQ_SYNC_EN to put a two-flop synchronizer on each irq
// line, for sources outside the clk domain.
//
// State table:
//   IDLE  | user bank; waiting for pending && IE && instr_done
//   SAVE  | sr1_wr holds the saved PC, stall asserted
//   ENTER | last stall cycle; next edge switches bank and acknowledges
//   SYS   | system bank; no nesting, waiting for reti && instr_done
module irq_ctrl #(
  parameter int NIRQ   = 4,
  parameter int IE_BIT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic [15:0]     cr_rd,
  input  logic [15:0]     pc,
  input  logic            instr_done,
  input  logic            reti,
  output logic            bank,
  output logic [15:0]     sr1_wr,
  output logic            stall,
  output logic [NIRQ-1:0] irq_ack,
  output logic [2:0]      irq_cause
);

  typedef enum logic [1:0] {IDLE, SAVE, ENTER, SYS} stateType;

  stateType        state, stateNxt;
  logic [NIRQ-1:0] irqIn, irqPrev, rise, pending, clrMask, causeOneHot;
  logic [2:0]      winner;
  logic            entryReq;
  logic            bankNxt, stallNxt;
  logic [15:0]     sr1Nxt;
  logic [NIRQ-1:0] ackNxt;
  logic [2:0]      causeNxt;
  logic            unusedCr;

  // Only the IE bit of the control register matters here.
  assign unusedCr = ^cr_rd;

`ifdef IRQ_SYNC_EN
  logic [NIRQ-1:0] syncA, syncB;

  // Two-flop synchronizer per request line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= irq;
      syncB <= syncA;
    end
  end

  assign irqIn = syncB;
`else
  assign irqIn = irq;
`endif

  assign rise = irqIn & ~irqPrev;

  // Lowest pending index wins; also decode the current cause as one-hot.
  always_comb begin
    winner      = '0;
    causeOneHot = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pending[i]) winner = 3'(i);
    end
    for (int i = 0; i < NIRQ; i++) begin
      causeOneHot[i] = (irq_cause == 3'(i));
    end
  end

  assign clrMask  = (state == ENTER) ? causeOneHot : '0;
  assign entryReq = (|pending) && cr_rd[IE_BIT] && instr_done;

  // Edge detector and sticky pending bits; a new edge beats its own clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irqPrev <= '0;
      pending <= '0;
    end else begin
      irqPrev <= irqIn;
      pending <= (pending & ~clrMask) | rise;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNxt;
  end

  // Next-state logic.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (entryReq) stateNxt = SAVE;
      SAVE:    stateNxt = ENTER;
      ENTER:   stateNxt = SYS;
      SYS:     if (reti && instr_done) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    bankNxt  = bank;
    sr1Nxt   = sr1_wr;
    stallNxt = stall;
    ackNxt   = '0;
    causeNxt = irq_cause;
    case (state)
      IDLE: begin
        if (entryReq) begin
          sr1Nxt   = pc;
          causeNxt = winner;
          stallNxt = 1'b1;
        end
      end
      ENTER: begin
        sr1Nxt   = '0;
        bankNxt  = 1'b1;
        ackNxt   = causeOneHot;
        stallNxt = 1'b0;
      end
      SYS: begin
        if (reti && instr_done) bankNxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank      <= 1'b0;
      sr1_wr    <= '0;
      stall     <= 1'b0;
      irq_ack   <= '0;
      irq_cause <= '0;
    end else begin
      bank      <= bankNxt;
      sr1_wr    <= sr1Nxt;
      stall     <= stallNxt;
      irq_ack   <= ackNxt;
      irq_cause <= causeNxt;
    end
  end

endmodule
